// File: rtl/mainm_arbiter.sv
// mainm_arbiter: round-robin arbiter/sequencer for the single main-memory port.
// Port 0 is the CPU path, port 1 a secondary master. One transaction is in
// flight at a time. A watchdog aborts transactions the memory never answers.
//
// Handshake: a requester raises we and/or rd (we wins) with a/d stable and holds
// them until it sees its one-cycle ready pulse, with spo valid in that cycle.
// Toward memory, mem_we/mem_rd are levels held until mem_ready pulses once.
module mainm_arbiter #(
   parameter int unsigned TIMEOUT  = 1024,
   parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] p0_a,
   input  logic [31:0] p0_d,
   input  logic        p0_we,
   input  logic        p0_rd,
   output logic [31:0] p0_spo,
   output logic        p0_ready,
   input  logic [31:0] p1_a,
   input  logic [31:0] p1_d,
   input  logic        p1_we,
   input  logic        p1_rd,
   output logic [31:0] p1_spo,
   output logic        p1_ready,
   output logic [31:0] mem_a,
   output logic [31:0] mem_d,
   output logic        mem_we,
   output logic        mem_rd,
   input  logic [31:0] mem_spo,
   input  logic        mem_ready,
   output logic        owner,
   output logic        busy,
   output logic        err,
   output logic        irq
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   // Counter value in the last BUSY cycle before the watchdog fires.
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [31:0] mem_a_q, mem_a_d, mem_d_q, mem_d_d;
   logic        mem_we_q, mem_we_d, mem_rd_q, mem_rd_d;
   logic [31:0] p0_spo_q, p0_spo_d, p1_spo_q, p1_spo_d;
   logic        p0_ready_q, p0_ready_d, p1_ready_q, p1_ready_d;
   logic        owner_q, owner_d, last_q, last_d;
   logic        err_q, err_d, irq_q, irq_d;
   logic [31:0] cnt_q, cnt_d;

   logic req0, req1, grant;

   assign req0  = p0_we | p0_rd;
   assign req1  = p1_we | p1_rd;
   // Both requesting: the port not served last wins; otherwise the lone requester.
   assign grant = (req0 & req1) ? ~last_q : req1;

   // Next-state and output logic for the IDLE/BUSY/DONE sequencer.
   always_comb begin
      state_d    = state_q;
      mem_a_d    = mem_a_q;
      mem_d_d    = mem_d_q;
      mem_we_d   = mem_we_q;
      mem_rd_d   = mem_rd_q;
      p0_spo_d   = p0_spo_q;
      p1_spo_d   = p1_spo_q;
      p0_ready_d = 1'b0;
      p1_ready_d = 1'b0;
      owner_d    = owner_q;
      last_d     = last_q;
      err_d      = err_q;
      irq_d      = 1'b0;
      cnt_d      = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req0 | req1) begin
               owner_d  = grant;
               last_d   = grant;
               mem_a_d  = grant ? p1_a : p0_a;
               mem_d_d  = grant ? p1_d : p0_d;
               mem_we_d = grant ? p1_we : p0_we;
               mem_rd_d = grant ? (p1_rd & ~p1_we) : (p0_rd & ~p0_we);
               cnt_d    = '0;
               state_d  = S_BUSY;
            end
         end
         S_BUSY: begin
            if (mem_ready) begin
               // Success wins over a simultaneous watchdog expiry.
               mem_we_d = 1'b0;
               mem_rd_d = 1'b0;
               if (owner_q) begin
                  p1_spo_d   = mem_spo;
                  p1_ready_d = 1'b1;
               end else begin
                  p0_spo_d   = mem_spo;
                  p0_ready_d = 1'b1;
               end
               state_d = S_DONE;
            end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
               mem_we_d = 1'b0;
               mem_rd_d = 1'b0;
               if (owner_q) begin
                  p1_spo_d   = ERR_WORD;
                  p1_ready_d = 1'b1;
               end else begin
                  p0_spo_d   = ERR_WORD;
                  p0_ready_d = 1'b1;
               end
               err_d   = 1'b1;
               irq_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_DONE: begin
            // No arbitration here so the just-served request cannot be re-granted.
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         mem_a_q    <= '0;
         mem_d_q    <= '0;
         mem_we_q   <= 1'b0;
         mem_rd_q   <= 1'b0;
         p0_spo_q   <= '0;
         p1_spo_q   <= '0;
         p0_ready_q <= 1'b0;
         p1_ready_q <= 1'b0;
         owner_q    <= 1'b0;
         last_q     <= 1'b1;
         err_q      <= 1'b0;
         irq_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         mem_a_q    <= mem_a_d;
         mem_d_q    <= mem_d_d;
         mem_we_q   <= mem_we_d;
         mem_rd_q   <= mem_rd_d;
         p0_spo_q   <= p0_spo_d;
         p1_spo_q   <= p1_spo_d;
         p0_ready_q <= p0_ready_d;
         p1_ready_q <= p1_ready_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         err_q      <= err_d;
         irq_q      <= irq_d;
         cnt_q      <= cnt_d;
      end
   end

   assign mem_a    = mem_a_q;
   assign mem_d    = mem_d_q;
   assign mem_we   = mem_we_q;
   assign mem_rd   = mem_rd_q;
   assign p0_spo   = p0_spo_q;
   assign p1_spo   = p1_spo_q;
   assign p0_ready = p0_ready_q;
   assign p1_ready = p1_ready_q;
   assign owner    = owner_q;
   assign busy     = (state_q != S_IDLE);
   assign err      = err_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_mainm_arbiter.sv
// tb_mainm_arbiter: directed and randomized transactions against a
// transaction-level reference model (round-robin winner, latency vs watchdog).
module tb_mainm_arbiter;

   localparam int          TO   = 8;
   localparam logic [31:0] ERRW = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] p0_a, p0_d, p1_a, p1_d;
   logic        p0_we, p0_rd, p1_we, p1_rd;
   logic [31:0] p0_spo, p1_spo;
   logic        p0_ready, p1_ready;
   logic [31:0] mem_a, mem_d, mem_spo;
   logic        mem_we, mem_rd, mem_ready;
   logic        owner, busy, err, irq;

   mainm_arbiter #(.TIMEOUT(TO), .ERR_WORD(ERRW)) dut (
      .clk(clk), .rst(rst),
      .p0_a(p0_a), .p0_d(p0_d), .p0_we(p0_we), .p0_rd(p0_rd),
      .p0_spo(p0_spo), .p0_ready(p0_ready),
      .p1_a(p1_a), .p1_d(p1_d), .p1_we(p1_we), .p1_rd(p1_rd),
      .p1_spo(p1_spo), .p1_ready(p1_ready),
      .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_rd(mem_rd),
      .mem_spo(mem_spo), .mem_ready(mem_ready),
      .owner(owner), .busy(busy), .err(err), .irq(irq)
   );

   // Clock
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Requester view and reference model state.
   logic        rq_we[2], rq_rd[2];
   logic [31:0] rq_a[2], rq_d[2];
   int          last_m;
   logic        err_m;
   logic [31:0] spo_m[2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ports();
      p0_we = rq_we[0]; p0_rd = rq_rd[0]; p0_a = rq_a[0]; p0_d = rq_d[0];
      p1_we = rq_we[1]; p1_rd = rq_rd[1]; p1_a = rq_a[1]; p1_d = rq_d[1];
   endtask

   function automatic bit pending(input int p);
      return rq_we[p] | rq_rd[p];
   endfunction

   task automatic set_req(input int p, input logic we, input logic rd,
                          input logic [31:0] a, input logic [31:0] d);
      rq_we[p] = we; rq_rd[p] = rd; rq_a[p] = a; rq_d[p] = d;
   endtask

   // kind 0: read, 1: write, 2: write with rd also set
   task automatic rand_req(input int p);
      int k;
      k = $urandom_range(0, 2);
      set_req(p, k != 0, k != 1, $urandom, $urandom);
   endtask

   task automatic model_reset();
      last_m   = 1;
      err_m    = 1'b0;
      spo_m[0] = '0;
      spo_m[1] = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_req(0, 0, 0, '0, '0);
      set_req(1, 0, 0, '0, '0);
      drive_ports();
      mem_ready = 1'b0;
      tick();
      tick();
      model_reset();
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_rd", 32'(mem_rd), 0);
      chk("rst_mem_a", mem_a, 0);
      chk("rst_mem_d", mem_d, 0);
      chk("rst_p0_ready", 32'(p0_ready), 0);
      chk("rst_p1_ready", 32'(p1_ready), 0);
      chk("rst_p0_spo", p0_spo, 0);
      chk("rst_p1_spo", p1_spo, 0);
      chk("rst_owner", 32'(owner), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_irq", 32'(irq), 0);
      rst = 1'b0;
   endtask

   // One full transaction starting in IDLE with requests already driven.
   // lat: BUSY cycle (1-based) in which memory answers; lat > TO means never.
   // mode 0: owner drops its request, 1: owner issues a new one, 2: random.
   task automatic run_txn(input int lat, input logic [31:0] rdata, input int mode);
      int          g, eff;
      bit          to;
      logic [31:0] ea, ed;
      logic        ewe, erd;
      if (pending(0) && pending(1)) g = (last_m == 1) ? 0 : 1;
      else g = pending(1) ? 1 : 0;
      last_m = g;
      ea  = rq_a[g];
      ed  = rq_d[g];
      ewe = rq_we[g];
      erd = rq_rd[g] & ~rq_we[g];
      to  = (lat > TO);
      eff = to ? TO : lat;
      tick();
      for (int c = 1; c <= eff; c++) begin
         chk("busy_on", 32'(busy), 1);
         chk("owner", 32'(owner), g);
         chk("mem_a", mem_a, ea);
         chk("mem_d", mem_d, ed);
         chk("mem_we", 32'(mem_we), 32'(ewe));
         chk("mem_rd", 32'(mem_rd), 32'(erd));
         chk("p0_ready_wait", 32'(p0_ready), 0);
         chk("p1_ready_wait", 32'(p1_ready), 0);
         if (c == lat) begin
            mem_ready = 1'b1;
            mem_spo   = rdata;
         end else begin
            mem_ready = 1'b0;
            mem_spo   = $urandom;
         end
         tick();
      end
      mem_ready = 1'b0;
      spo_m[g] = to ? ERRW : rdata;
      if (to) err_m = 1'b1;
      // DONE cycle
      chk("p0_ready_done", 32'(p0_ready), (g == 0) ? 1 : 0);
      chk("p1_ready_done", 32'(p1_ready), (g == 1) ? 1 : 0);
      chk("p0_spo", p0_spo, spo_m[0]);
      chk("p1_spo", p1_spo, spo_m[1]);
      chk("mem_we_off", 32'(mem_we), 0);
      chk("mem_rd_off", 32'(mem_rd), 0);
      chk("irq_done", 32'(irq), 32'(to));
      chk("err_done", 32'(err), 32'(err_m));
      chk("busy_done", 32'(busy), 1);
      if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) rand_req(g);
      else set_req(g, 0, 0, $urandom, $urandom);
      if (mode == 2 && !pending(1 - g) && $urandom_range(0, 1) == 1) rand_req(1 - g);
      drive_ports();
      mem_ready = 1'($urandom_range(0, 1));
      tick();
      mem_ready = 1'b0;
      // IDLE cycle
      chk("busy_idle", 32'(busy), 0);
      chk("p0_ready_idle", 32'(p0_ready), 0);
      chk("p1_ready_idle", 32'(p1_ready), 0);
      chk("irq_idle", 32'(irq), 0);
      chk("err_idle", 32'(err), 32'(err_m));
   endtask

   initial begin
      int lat;
      mem_spo   = '0;
      mem_ready = 1'b0;
      do_reset();

      // Single read, memory answers in 3rd BUSY cycle.
      set_req(0, 0, 1, 32'h20000010, 32'h0);
      drive_ports();
      run_txn(3, 32'h12345678, 0);

      // Spurious mem_ready while idle.
      mem_ready = 1'b1;
      mem_spo   = 32'h55AA55AA;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("spur_busy", 32'(busy), 0);
         chk("spur_p0_ready", 32'(p0_ready), 0);
         chk("spur_p1_ready", 32'(p1_ready), 0);
         chk("spur_p0_spo", p0_spo, spo_m[0]);
      end
      mem_ready = 1'b0;

      // Contention from reset: alternating grants.
      do_reset();
      rand_req(0);
      rand_req(1);
      drive_ports();
      for (int i = 0; i < 4; i++) run_txn(1, $urandom, 1);
      run_txn(1, $urandom, 0);
      run_txn(1, $urandom, 0);

      // Write with both strobes set.
      set_req(1, 1, 1, $urandom, 32'hCAFEF00D);
      drive_ports();
      run_txn(2, $urandom, 0);

      // mem_ready in the same cycle as the watchdog expiry: success.
      set_req(0, 0, 1, $urandom, $urandom);
      drive_ports();
      run_txn(TO, 32'h0BADF00D, 0);

      // Memory never answers: watchdog abort.
      set_req(0, 0, 1, $urandom, $urandom);
      drive_ports();
      run_txn(TO + 1, $urandom, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("err_sticky", 32'(err), 1);
      end

      // Reset mid-BUSY.
      do_reset();
      set_req(0, 0, 1, 32'h1000, $urandom);
      drive_ports();
      tick();
      tick();
      rst = 1'b1;
      set_req(0, 0, 0, '0, '0);
      drive_ports();
      tick();
      rst = 1'b0;
      model_reset();
      chk("mrst_mem_we", 32'(mem_we), 0);
      chk("mrst_mem_rd", 32'(mem_rd), 0);
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_p0_ready", 32'(p0_ready), 0);
      chk("mrst_owner", 32'(owner), 0);
      tick();
      chk("mrst_p0_ready2", 32'(p0_ready), 0);
      chk("mrst_busy2", 32'(busy), 0);
      set_req(1, 0, 1, $urandom, $urandom);
      drive_ports();
      run_txn(2, $urandom, 0);

      // Randomized traffic.
      for (int i = 0; i < 80; i++) begin
         if (!pending(0) && !pending(1)) begin
            case ($urandom_range(0, 2))
               0: rand_req(0);
               1: rand_req(1);
               default: begin rand_req(0); rand_req(1); end
            endcase
            drive_ports();
         end
         lat = ($urandom_range(0, 9) == 0) ? TO + 1 : int'($urandom_range(1, TO));
         run_txn(lat, $urandom, 2);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mainm_arbiter.md
Name: mainm_arbiter

Overview:
- Two-requester arbiter and sequencer for the single main-memory port (a/d/we/rd/spo/ready handshake).
- Port 0 is the CPU-side path out of the memory mapper; port 1 is a secondary master, e.g. a video framebuffer fetcher or a DMA engine.
- Grants round-robin, one transaction at a time, and holds memory strobes until the memory returns ready.
- Returns a registered response to the winning port; a watchdog aborts hung transactions.

Parameters:
- TIMEOUT, 1024: cycles in BUSY before an abort; 0 disables the watchdog.
- ERR_WORD, 32'hDEADBEEF: read data returned on an aborted transaction.

Ports:
- clk  in  1  system clock (clk_main)
- rst  in  1  synchronous, active-high reset
- p0_a  in  32  port 0 address
- p0_d  in  32  port 0 write data
- p0_we  in  1  port 0 write request, level
- p0_rd  in  1  port 0 read request, level
- p0_spo  out  32  port 0 read data, valid while p0_ready=1
- p0_ready  out  1  port 0 completion pulse, 1 cycle
- p1_a, p1_d, p1_we, p1_rd, p1_spo, p1_ready: same as port 0, for port 1
- mem_a  out  32  memory address
- mem_d  out  32  memory write data
- mem_we  out  1  memory write strobe, level
- mem_rd  out  1  memory read strobe, level
- mem_spo  in  32  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion, 1-cycle pulse
- owner  out  1  port currently or last granted
- busy  out  1  state != IDLE
- err  out  1  sticky timeout flag, cleared only by rst
- irq  out  1  1-cycle pulse on timeout

Behaviour:
- Clock and reset: one clock, clk. Reset is rst: synchronous, active-high.
- Reset values: state=IDLE; mem_we=mem_rd=0; mem_a=mem_d=0; p*_ready=0; p*_spo=0; owner=0; last=1; err=0; irq=0; counter=0.
- Request definition: reqX = pX_we | pX_rd. If both we and rd are set, the transaction is a write (we wins).
- Requester rule: a requester holds a/d/we/rd stable from assertion until it sees its ready pulse. It must drop or change its request in the cycle after the pulse.
- State IDLE:
  - If only one port requests, grant it.
  - If both request, grant !last (round-robin). After reset, port 0 wins first.
  - On grant (edge ending cycle N): owner<=g, last<=g. Register mem_a/mem_d from port g. mem_we<=pg_we; mem_rd<=pg_rd & ~pg_we. Counter<=0. Go to BUSY. Strobes are visible from cycle N+1.
- State BUSY:
  - mem_a/d/we/rd stay constant. The non-owner port's request is ignored; it keeps waiting.
  - mem_ready=1 in cycle M: strobes<=0; pg_spo<=mem_spo (write: spo<=mem_spo as well, contents don't-care); pg_ready<=1; go to DONE. The ready pulse appears in cycle M+1.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: strobes<=0; pg_spo<=ERR_WORD; pg_ready<=1; err<=1; irq<=1; go to DONE.
  - Else counter++. The counter is 32-bit and never wraps before TIMEOUT.
- State DONE: lasts one cycle. pg_ready=1 and irq as set. Next state is IDLE with ready and irq cleared. No arbitration happens in DONE, so a stale request is never re-granted.
- Throughput: minimum 3 cycles per transaction when the memory answers in the first BUSY cycle: IDLE grant, BUSY, DONE.
- Spurious mem_ready (in IDLE or DONE) is ignored.
- mem_ready in the same cycle as the timeout: success takes priority; no err or irq.
- p*_spo holds its last value between pulses.
- rst in any state returns all outputs to reset values at the next edge, including mid-BUSY. Strobes drop and no ready is issued for the aborted transaction.
- Starvation bound: a continuously requesting port waits at most one transaction of the other port.

Test Plan:
- Single read: p0_rd=1, p0_a=0x20000010; memory answers mem_ready in the 3rd BUSY cycle with mem_spo=0x12345678 -> mem_rd=1 and mem_a=0x20000010 for 3 cycles; next cycle p0_ready=1 with p0_spo=0x12345678; p1_ready never asserts.
- Contention: p0 and p1 both request from reset, memory 1-cycle latency -> grants p0, p1, p0, p1 alternately; each ready 3 cycles apart; owner toggles accordingly.
- Write with both strobes: p1_we=1, p1_rd=1, p1_d=0xCAFEF00D -> mem_we=1, mem_rd=0, mem_d=0xCAFEF00D; p1_ready pulses once.
- Timeout: TIMEOUT=8, memory never ready -> strobes high exactly 8 cycles; then p0_ready=1 with p0_spo=0xDEADBEEF; irq is a 1-cycle pulse; err stays 1 until rst.
- Edge cases: mem_ready on the same cycle as the timeout -> normal completion, err=0. Spurious mem_ready in IDLE -> no ready pulses.
- Reset mid-BUSY: assert rst for 1 cycle -> strobes=0 at the next edge, no ready pulse, busy=0; a following p1 request is granted normally.
